// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: bubble encoding, fetch FSM states, IF/ID layout and
// the opcodes the fetch, hazard and control logic all agree on.
package mips_pkg;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef enum logic {
    StRun  = 1'b0,
    StKill = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold, or flush to a bubble that keeps the old PC+4.
// Flush takes priority over hold.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);
  import mips_pkg::*;

  ifid_t ifid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
    end else if (flush) begin
      ifid_q.instr <= NOP_INSTR;
      ifid_q.valid <= 1'b0;
    end else if (write) begin
      ifid_q <= '{instr: load_instr, pc4: load_pc4, valid: 1'b1};
    end
  end

  assign instr = ifid_q.instr;
  assign pc4   = ifid_q.pc4;
  assign valid = ifid_q.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, wait-state tolerant imem request and redirect handling.
// A redirect during an unfinished fetch parks in StKill until the stale data arrives.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);
  import mips_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redir;
  logic         ifid_load;
  logic         ifid_flush;

  assign redir    = pc_write & (jump | branch_taken);
  assign target   = word_align(jump ? jump_target : branch_target);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!pc_write) begin
          // Returned data is dropped; the same PC is refetched once the stall clears.
          ifid_flush = ifid_write;
        end else if (redir) begin
          ifid_flush = 1'b1;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            redirect_pc_d = target;
            state_d       = StKill;
          end
        end else if (imem_ready) begin
          pc_d      = pc_plus4;
          ifid_load = ifid_write;
        end else begin
          ifid_flush = ifid_write;
        end
      end
      StKill: begin
        ifid_flush = ifid_write;
        if (redir) begin
          redirect_pc_d = target;
        end
        if (imem_ready) begin
          pc_d    = redir ? target : redirect_pc_q;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .write     (ifid_load),
    .flush     (ifid_flush),
    .load_instr(imem_rdata),
    .load_pc4  (pc_plus4),
    .instr     (ifid_instr),
    .pc4       (ifid_pc4),
    .valid     (ifid_valid)
  );

  // Request is held off only while reset is asserted.
  assign imem_req  = rst_n;
  assign imem_addr = pc_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural fetch model pushes expected PC/IF-ID per
// cycle, popped and compared after each clock edge, plus directed fetch-scenario checks.
module tb_if_stage;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, ifid_write, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, pc, ifid_instr, ifid_pc4;

  if_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc, m_rp, m_instr, m_pc4;
  logic        m_kill, m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_rp = 32'h0; m_kill = 1'b0;
    m_instr = NOP_INSTR; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic bubble_if(input logic en);
    if (en) begin
      m_instr = NOP_INSTR;
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic pw, input logic iw, input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic rdy,
                       input logic [31:0] rd);
    logic        rdr;
    logic [31:0] tgt;
    exp_t        e;
    pc_write = pw; ifid_write = iw; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; imem_ready = rdy; imem_rdata = rd;
    check("imem_addr", imem_addr, m_pc);
    check("imem_req", {31'h0, imem_req}, 32'h1);
    rdr = pw & (j | br);
    tgt = (j ? jt : bt) & 32'hFFFF_FFFC;
    if (!m_kill) begin
      if (!pw) begin
        bubble_if(iw);
      end else if (rdr) begin
        bubble_if(1'b1);
        if (rdy) m_pc = tgt;
        else begin
          m_rp = tgt;
          m_kill = 1'b1;
        end
      end else if (rdy) begin
        if (iw) begin
          m_instr = rd; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else begin
        bubble_if(iw);
      end
    end else begin
      bubble_if(iw);
      if (rdr) m_rp = tgt;
      if (rdy) begin
        m_pc = m_rp;
        m_kill = 1'b0;
      end
    end
    sb_q.push_back('{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'h0, 32'h1);
    end else begin
      e = sb_q.pop_front();
      check("pc", pc, e.pc);
      check("ifid_instr", ifid_instr, e.instr);
      check("ifid_pc4", ifid_pc4, e.pc4);
      check("ifid_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
    end
  endtask

  // Plain sequential fetch with ready, no redirect
  task automatic fetch(input logic [31:0] rd);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rd);
  endtask

  initial begin
    rst_n = 1'b0;
    pc_write = 1'b1; ifid_write = 1'b1; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    model_reset();
    #12;
    check("rst_pc", pc, RST_PC);
    check("rst_instr", ifid_instr, NOP_INSTR);
    check("rst_pc4", ifid_pc4, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch
    fetch(32'h2008_0005);
    check("seq_pc", pc, 32'h4);
    check("seq_instr", ifid_instr, 32'h2008_0005);
    check("seq_pc4", ifid_pc4, 32'h4);
    fetch(32'h1111_0001);
    fetch(32'h1111_0002);
    fetch(32'h1111_0003);
    check("seq_pc3", pc, 32'h10);

    // Load-use stall with an ignored branch
    cycle(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
    check("stall_pc", pc, 32'h10);
    check("stall_instr", ifid_instr, 32'h1111_0003);
    fetch(32'h2222_0010);
    check("resume_pc4", ifid_pc4, 32'h14);

    // Taken beq flushes IF/ID
    cycle(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h3333_0014);
    check("beq_pc", pc, 32'h40);
    check("beq_instr", ifid_instr, NOP_INSTR);
    fetch(32'h4444_0040);
    check("beq_next_pc4", ifid_pc4, 32'h44);

    // Hold IF/ID while PC advances, then a stall-bubble with ifid_write=1
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5555_0044);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch(32'h5555_0048);

    // Redirect during wait state
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0);
    check("kill_addr", imem_addr, 32'h20);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    check("kill_pc", pc, 32'h100);
    check("kill_valid", {31'h0, ifid_valid}, 32'h0);

    // Double redirect in KILL, latest wins; low address bits masked
    cycle(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h203, 1'b1, 32'hDEAD_0001);
    check("dbl_pc", pc, 32'h200);
    fetch(32'h6666_0200);

    // Wrap at top of address space
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
    fetch(32'h7777_FFFC);
    check("wrap_pc", pc, 32'h0);
    check("wrap_pc4", ifid_pc4, 32'h0);

    // Reset mid-KILL
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_pc", pc, RST_PC);
    check("midrst_valid", {31'h0, ifid_valid}, 32'h0);
    check("midrst_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h8888_0000);
    check("postrst_pc", pc, 32'h4);
    check("postrst_instr", ifid_instr, 32'h8888_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory request interface and the IF/ID pipeline register.
- Consumes the stall controls (pc_write, ifid_write) from the hazard check unit.
- Consumes branch (beq resolved in ID) and jump redirects from ID.
- Feeds instruction, PC+4 and valid to the decode stage and the hazard unit's IF/ID Rs/Rt fields.
- Tolerates a wait-stated instruction memory, and discards an in-flight fetch when it is redirected.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID as a bubble (sll $0,$0,0)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous assert, active-low
pc_write  in  1  from hazard unit; 0 = hold PC, ignore redirects
ifid_write  in  1  from hazard unit; 0 = hold IF/ID contents
branch_taken  in  1  ID: beq resolved taken
branch_target  in  32  ID: beq target address
jump  in  1  ID: j/jal
jump_target  in  32  ID: jump target address
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_rdata  in  32  instruction word; valid when imem_ready=1
imem_ready  in  1  fetch completes this cycle
pc  out  32  current fetch PC
ifid_instr  out  32  IF/ID instruction
ifid_pc4  out  32  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset, asynchronous on rst_n=0:
  - pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0.
  - state=RUN, redirect_pc=0, imem_req=0.
- While rst_n=1, imem_req=1 every cycle.
- Address outputs:
  - imem_addr=pc in both states. In KILL, pc still holds the abandoned address, so the address stays stable until imem_ready.
  - The low 2 bits of every loaded target are forced to 00.
- Redirect: redir = pc_write & (jump | branch_taken). Target is jump_target when jump=1, else branch_target; jump wins if both are asserted.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- RUN state, evaluated at the clock edge, highest priority first:
  - pc_write=0: pc holds; any returned data is dropped (it is refetched later); IF/ID holds if ifid_write=0, else loads a bubble.
  - redir & imem_ready: pc<=target; IF/ID <= bubble (flush overrides ifid_write); stay in RUN.
  - redir & !imem_ready: redirect_pc<=target; IF/ID <= bubble; go to KILL.
  - imem_ready: pc<=pc+4; if ifid_write, IF/ID <= {imem_rdata, pc+4, valid=1}, else hold.
  - !imem_ready: pc holds; IF/ID <= bubble if ifid_write, else hold.
- KILL state (the outstanding fetch is discarded):
  - redir: redirect_pc<=new target; the latest redirect wins.
  - imem_ready: data dropped; pc <= redirect_pc, or the new target if redir is asserted this same cycle; go to RUN.
  - IF/ID: bubble if ifid_write, else hold.
- Definitions:
  - A bubble is {NOP_INSTR, ifid_pc4 unchanged, valid=0}.
  - One-cycle latency: an instruction accepted at edge N is visible on ifid_* after edge N.
- Reset mid-KILL: returns to RUN at RESET_PC; a late imem_ready after reset is treated as a normal fetch of RESET_PC.
- No branch delay slot: a redirect always kills the sequential instruction.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR constant
  - fetch state enum (RUN=1'b0, KILL=1'b1)
  - opcode constants (OP_BEQ=6'b000100, OP_J, OP_JAL), shared with the hazard unit and control
- One sub-module, if_id_reg: 65-bit register with async active-low reset, hold (ifid_write=0) and flush-to-bubble inputs; flush has priority over hold.
- The PC, state and redirect logic stay in if_stage.

Test Plan:
1. Sequential fetch: reset release, imem_ready=1, rdata=0x20080005 at pc=0 → after the edge pc=4, ifid_instr=0x20080005, ifid_pc4=4, ifid_valid=1; after 3 more edges pc=0x10.
2. Load-use stall: pc_write=0, ifid_write=0 for 1 cycle at pc=0x10 → pc stays 0x10, IF/ID unchanged, branch_taken=1 in that cycle ignored; on the next cycle the fetch resumes at 0x10.
3. Taken beq: branch_taken=1, branch_target=0x40, ready=1 at pc=0x14 → pc=0x40, ifid_valid=0, ifid_instr=0; the next edge fetches 0x40.
4. Redirect during wait: jump=1, target=0x100, imem_ready=0 at pc=0x20 → state KILL, imem_addr stays 0x20; 2 cycles later ready=1 → rdata dropped, pc=0x100, ifid_valid=0.
5. Double redirect in KILL: branch target 0x80 latched, then jump=1 to 0x200 in the cycle ready rises → pc=0x200.
6. Wrap and reset: pc=0xFFFFFFFC, ready=1 → pc=0; assert rst_n=0 mid-KILL → pc=RESET_PC immediately, ifid_valid=0, imem_req=0.
